// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Brief    : EX-stage forward selects, load-use stall and branch flush control
//            with saturating stall/flush event counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_forward_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_wr,
   input  logic              id_mem_rd,
   input  logic              br_taken,
   output logic [1:0]        FselA,
   output logic [1:0]        FselB,
   output logic              stall_if_id,
   output logic              flush_ex,
   output logic              flush_id,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] c_sel_rf  = 2'b00;
   localparam logic [1:0] c_sel_mem = 2'b01;
   localparam logic [1:0] c_sel_wb  = 2'b10;

   // Only EX and MEM destinations steer any output, so WB tracking is not kept.
   logic [REG_AW-1:0] r_ex_rd;
   logic              r_ex_wr;
   logic              r_ex_ld;
   logic [REG_AW-1:0] r_mem_rd;
   logic              r_mem_wr;
   logic [1:0]        r_fsel_a;
   logic [1:0]        r_fsel_b;
   logic [CNT_W-1:0]  r_stall_cnt;
   logic [CNT_W-1:0]  r_flush_cnt;

   logic              w_lu;
   logic              w_stall;
   logic              w_bubble;
   logic [1:0]        w_fsel_a_nxt;
   logic [1:0]        w_fsel_b_nxt;

   function automatic logic [1:0] fwd_sel(input logic use_rs, input logic [REG_AW-1:0] rs);
      logic [1:0] sel;
      sel = c_sel_rf;
      if (use_rs && r_ex_wr && (r_ex_rd == rs) && (r_ex_rd != '0))
         sel = c_sel_mem;
      else if (use_rs && r_mem_wr && (r_mem_rd == rs) && (r_mem_rd != '0))
         sel = c_sel_wb;
      return sel;
   endfunction

   always_comb begin
      w_lu = id_valid && r_ex_ld && (r_ex_rd != '0) &&
             ((id_use_rs1 && (id_rs1 == r_ex_rd)) || (id_use_rs2 && (id_rs2 == r_ex_rd)));
      // A taken branch discards the stalled instruction, so flush beats stall.
      w_stall      = w_lu && !br_taken;
      w_bubble     = w_lu || br_taken;
      w_fsel_a_nxt = w_bubble ? c_sel_rf : fwd_sel(id_use_rs1, id_rs1);
      w_fsel_b_nxt = w_bubble ? c_sel_rf : fwd_sel(id_use_rs2, id_rs2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_rd     <= '0;
         r_ex_wr     <= 1'b0;
         r_ex_ld     <= 1'b0;
         r_mem_rd    <= '0;
         r_mem_wr    <= 1'b0;
         r_fsel_a    <= c_sel_rf;
         r_fsel_b    <= c_sel_rf;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_bubble) begin
            r_ex_rd <= '0;
            r_ex_wr <= 1'b0;
            r_ex_ld <= 1'b0;
         end else begin
            r_ex_rd <= id_rd;
            r_ex_wr <= id_reg_wr && id_valid;
            r_ex_ld <= id_mem_rd && id_valid;
         end
         r_mem_rd <= r_ex_rd;
         r_mem_wr <= r_ex_wr;
         r_fsel_a <= w_fsel_a_nxt;
         r_fsel_b <= w_fsel_b_nxt;
         if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (br_taken && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

   assign FselA       = r_fsel_a;
   assign FselB       = r_fsel_b;
   assign stall_if_id = w_stall;
   assign flush_ex    = w_bubble;
   assign flush_id    = br_taken;
   assign stall_cnt   = r_stall_cnt;
   assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_unit
// Brief    : Directed vector bench for hazard_forward_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_forward_unit;

   localparam int CW = 4;

   logic          clk, rst, id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_mem_rd, br_taken;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic [1:0]    FselA, FselB;
   logic          stall_if_id, flush_ex, flush_id;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int total = 0;
   int bad   = 0;
   int exp_sc = 0;
   int exp_fc = 0;

   hazard_forward_unit #(.REG_AW(5), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
      .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd), .br_taken(br_taken),
      .FselA(FselA), .FselB(FselB), .stall_if_id(stall_if_id), .flush_ex(flush_ex),
      .flush_id(flush_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic       br;
      logic       e_st;
      logic       e_fex;
      logic       e_fid;
      logic [1:0] e_fa;
      logic [1:0] e_fb;
   } vec_t;

   vec_t vecs[23];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic wr, input logic ld, input logic br);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      id_rd = rd; id_reg_wr = wr; id_mem_rd = ld; br_taken = br;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // valid rs1 rs2 u1 u2 rd wr ld br | stall fex fid FselA FselB
      vecs[0]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[1]  = '{1'b1, 5'd5,  5'd5,  1'b1, 1'b1, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
      vecs[2]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[3]  = '{1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[4]  = '{1'b1, 5'd7,  5'd1,  1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      vecs[5]  = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[6]  = '{1'b1, 5'd3,  5'd4,  1'b1, 1'b1, 5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[7]  = '{1'b1, 5'd7,  5'd7,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01};
      vecs[8]  = '{1'b1, 5'd2,  5'd0,  1'b1, 1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[9]  = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
      vecs[10] = '{1'b1, 5'd9,  5'd0,  1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      vecs[11] = '{1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[12] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[13] = '{1'b1, 5'd1,  5'd0,  1'b0, 1'b0, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[14] = '{1'b1, 5'd3,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[15] = '{1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[16] = '{1'b1, 5'd4,  5'd0,  1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[17] = '{1'b0, 5'd11, 5'd0,  1'b1, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      vecs[18] = '{1'b1, 5'd11, 5'd0,  1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
      vecs[19] = '{1'b1, 5'd12, 5'd0,  1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
      vecs[20] = '{1'b1, 5'd13, 5'd12, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      vecs[21] = '{1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
      vecs[22] = '{1'b1, 5'd14, 5'd0,  1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};

      rst = 1'b1;
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick;
      chk("reset FselA", int'(FselA), 0);
      chk("reset FselB", int'(FselB), 0);
      chk("reset stall", int'(stall_if_id), 0);
      chk("reset flush_ex", int'(flush_ex), 0);
      chk("reset stall_cnt", int'(stall_cnt), 0);
      rst = 1'b0;

      // T1: build up a live stall with nonzero Fsel and counter, then reset mid-cycle
      drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);   // lw x9
      tick;
      drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);  // add x10,x9
      tick;
      drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);   // lw x3,(x9)
      tick;
      chk("t1 pre FselA", int'(FselA), 2);
      chk("t1 pre stall_cnt", int'(stall_cnt), 1);
      drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);   // use x3
      #1;
      chk("t1 pre stall", int'(stall_if_id), 1);
      #1 rst = 1'b1;
      #1;
      chk("t1 stall", int'(stall_if_id), 0);
      chk("t1 flush_ex", int'(flush_ex), 0);
      chk("t1 flush_id", int'(flush_id), 0);
      chk("t1 FselA", int'(FselA), 0);
      chk("t1 FselB", int'(FselB), 0);
      chk("t1 stall_cnt", int'(stall_cnt), 0);
      chk("t1 flush_cnt", int'(flush_cnt), 0);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick;
      rst = 1'b0;

      // T2..T6 vector table, pipeline state carries from one row to the next
      for (int i = 0; i < 23; i++) begin
         drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2,
               vecs[i].rd, vecs[i].wr, vecs[i].ld, vecs[i].br);
         #1;
         chk($sformatf("v%0d stall", i), int'(stall_if_id), int'(vecs[i].e_st));
         chk($sformatf("v%0d flush_ex", i), int'(flush_ex), int'(vecs[i].e_fex));
         chk($sformatf("v%0d flush_id", i), int'(flush_id), int'(vecs[i].e_fid));
         if (vecs[i].e_st && exp_sc < 15) exp_sc++;
         if (vecs[i].e_fid && exp_fc < 15) exp_fc++;
         tick;
         chk($sformatf("v%0d FselA", i), int'(FselA), int'(vecs[i].e_fa));
         chk($sformatf("v%0d FselB", i), int'(FselB), int'(vecs[i].e_fb));
         chk($sformatf("v%0d stall_cnt", i), int'(stall_cnt), exp_sc);
         chk($sformatf("v%0d flush_cnt", i), int'(flush_cnt), exp_fc);
      end

      // T6 saturation: flush count from 2 up to 15, then one more flush
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (13) tick;
      chk("sat flush_cnt at max", int'(flush_cnt), 15);
      tick;
      chk("sat flush_cnt held", int'(flush_cnt), 15);
      chk("sat stall_cnt", int'(stall_cnt), 1);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      tick;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
